itch_tx_serializer: RTL
=======================

// Module: itch_tx_serializer
// PURPOSE
//  Transmit-side counterpart of the ITCH ingest path: takes one book message per handshake
//  (ADD/CANCEL/EXEC fields) and serializes it into a framed 64-bit Avalon-ST stream (sop/eop/empty).
//  Used for replay/test-traffic generation and loopback into the parser.
//  Frame layout is little-endian within and across words.
//  Byte 0 = total length; 1 = type char; 2..9 = order_id (8B, upper 4B zero);
//  ADD: 10 = side, 11..14 = qty, 15..18 = price.  EXEC: 10..13 = qty.
// PARAMETERS
//  STREAM_W  64  stream data width in bits; only 64 supported (elaboration error otherwise)
//  IDLE_GAP  0   minimum idle cycles inserted after each eop beat (0..255)
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   async active-low reset
//  in_valid    in   1   message valid
//  in_ready    out  1   message accepted when in_valid&&in_ready
//  in_mtype    in   2   0=ADD('A') 1=CANCEL('D') 2=EXEC('E') 3=reserved
//  in_side     in   1   0=BID('B') 1=ASK('S'); used for ADD only
//  in_order_id in   32  order id
//  in_qty      in   32  quantity (ADD, EXEC)
//  in_price    in   32  price tick (ADD)
//  m_valid     out  1   stream beat valid
//  m_ready     in   1   downstream ready
//  m_data      out  64  beat data, byte k of beat = m_data[8k+:8]
//  m_sop       out  1   first beat of frame
//  m_eop       out  1   last beat of frame
//  m_empty     out  3   unused bytes on eop beat (0 when m_eop=0)
//  msg_cnt     out  32  frames fully sent (eop handshaken), wraps 2^32-1 -> 0
//  drop_cnt    out  16  reserved-type messages accepted and discarded, wraps
// BEHAVIOUR
//  Reset clears all regs: m_valid/m_sop/m_eop=0, m_data=0, m_empty=0, counters 0, state IDLE.
//  FSM IDLE -> SEND -> (GAP) -> IDLE.
//  IDLE: in_ready=1.
//   - On accept: latch fields into a 24-byte frame buffer; unused bytes are 0.
//   - Set beat index to 0 and go to SEND.
//   - Reserved type: accept, drop_cnt+1, stay IDLE, no output.
//  SEND: in_ready=0; m_valid=1 with the current beat.
//   - Frame sizes: ADD len 19 = 3 beats, empty 5; CANCEL len 10 = 2 beats, empty 6;
//     EXEC len 14 = 2 beats, empty 2.
//   - m_sop on beat 0 only; m_eop/m_empty on last beat only.
//   - Beat held stable (data, sop, eop, empty) while m_valid&&!m_ready; advance only on handshake.
//   - On eop handshake: msg_cnt+1; go to GAP if IDLE_GAP>0, else IDLE.
//  GAP: m_valid=0, in_ready=0; count IDLE_GAP cycles, then go to IDLE.
//  Latency: accept at cycle t -> sop beat valid at t+1. One-cycle IDLE between frames
//   (max one frame per beats+1 cycles when IDLE_GAP=0).
//  m_valid never deasserts mid-frame except on reset.
//  Reset mid-frame abandons the frame with no eop; msg_cnt is not incremented.
//  Input fields are sampled only on accept; later changes are ignored.
// TESTING
//  1 ADD oid=0x11223344, BID, qty=0x64, price=0x1F40, m_ready=1.
//    -> beat0 0x0000112233444113 sop; beat1 0x4000000064420000; beat2 0x000000000000001F eop empty=5;
//    msg_cnt=1.
//  2 CANCEL oid=0xDEADBEEF -> 0x0000DEADBEEF440A sop; 0x0 eop empty=6.
//  3 EXEC oid=0x5, qty=0x0A0B0C0D.
//    -> 0x000000000005450E sop; 0x000000000A0B0C0D0000 truncated to 64b = 0x00000A0B0C0D0000 eop empty=2.
//  4 Test 1 with m_ready toggled 1-0-0-1 random -> identical beats, each held stable while stalled;
//    in_ready=0 throughout.
//  5 in_mtype=3 -> no beats, drop_cnt=1, in_ready stays 1.
//    Back-to-back 2x CANCEL with IDLE_GAP=2 -> 2 idle cycles after each eop.
//  6 rst_n low during beat1 of ADD -> m_valid=0 immediately, msg_cnt=0.
//    Next CANCEL is sent correctly with sop.

Source files
------------

// File: rtl/itch_tx_serializer.sv
// ITCH transmit serializer: packs one ADD/CANCEL/EXEC book message per handshake
// into a little-endian framed 64-bit Avalon-ST stream (sop/eop/empty).
module itch_tx_serializer #(
  parameter int unsigned STREAM_W = 64,
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mtype,
  input  logic                in_side,
  input  logic [31:0]         in_order_id,
  input  logic [31:0]         in_qty,
  input  logic [31:0]         in_price,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [STREAM_W-1:0] m_data,
  output logic                m_sop,
  output logic                m_eop,
  output logic [2:0]          m_empty,
  output logic [31:0]         msg_cnt,
  output logic [15:0]         drop_cnt
);

  localparam int unsigned BEAT_W  = STREAM_W;
  localparam int unsigned FRAME_W = 3 * BEAT_W;
  localparam int unsigned GAP_W   = 8;

  localparam logic [1:0] MT_ADD    = 2'd0;
  localparam logic [1:0] MT_CANCEL = 2'd1;
  localparam logic [1:0] MT_EXEC   = 2'd2;

  if (STREAM_W != 64) begin : g_bad_stream_w
    $error("itch_tx_serializer: only STREAM_W=64 is supported");
  end
  if (IDLE_GAP > 255) begin : g_bad_idle_gap
    $error("itch_tx_serializer: IDLE_GAP must be 0..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t               state, state_d;
  logic [FRAME_W-1:0]   frame_buf, frame_buf_d, frame_c;
  logic [1:0]           beat, beat_d, beat_nx;
  logic [1:0]           last, last_d, frame_last_c;
  logic [2:0]           last_empty, last_empty_d, frame_empty_c;
  logic                 frame_keep_c;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_d;
  logic                 in_ready_d, m_valid_d, m_sop_d, m_eop_d;
  logic [BEAT_W-1:0]    m_data_d;
  logic [2:0]           m_empty_d;
  logic [31:0]          msg_cnt_d;
  logic [15:0]          drop_cnt_d;

  // Assemble the full frame image straight from the input fields
  always_comb begin
    frame_c         = '0;
    frame_last_c    = 2'd1;
    frame_empty_c   = 3'd6;
    frame_keep_c    = 1'b1;
    frame_c[16 +: 32] = in_order_id;
    case (in_mtype)
      MT_ADD: begin
        frame_c[7:0]      = 8'd19;
        frame_c[15:8]     = 8'h41;
        frame_c[87:80]    = in_side ? 8'h53 : 8'h42;
        frame_c[88 +: 32] = in_qty;
        frame_c[120 +: 32] = in_price;
        frame_last_c      = 2'd2;
        frame_empty_c     = 3'd5;
      end
      MT_CANCEL: begin
        frame_c[7:0]  = 8'd10;
        frame_c[15:8] = 8'h44;
      end
      MT_EXEC: begin
        frame_c[7:0]      = 8'd14;
        frame_c[15:8]     = 8'h45;
        frame_c[80 +: 32] = in_qty;
        frame_empty_c     = 3'd2;
      end
      default: begin
        frame_c      = '0;
        frame_keep_c = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (in_valid && in_ready && frame_keep_c) state_d = S_SEND;
      S_SEND: if (m_ready && m_eop) state_d = (IDLE_GAP != 0) ? S_GAP : S_IDLE;
      S_GAP:  if (gap_cnt == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and frame datapath
  always_comb begin
    frame_buf_d  = frame_buf;
    beat_d       = beat;
    last_d       = last;
    last_empty_d = last_empty;
    gap_cnt_d    = gap_cnt;
    m_valid_d    = m_valid;
    m_data_d     = m_data;
    m_sop_d      = m_sop;
    m_eop_d      = m_eop;
    m_empty_d    = m_empty;
    msg_cnt_d    = msg_cnt;
    drop_cnt_d   = drop_cnt;
    beat_nx      = beat + 2'd1;
    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          if (frame_keep_c) begin
            frame_buf_d  = frame_c;
            beat_d       = 2'd0;
            last_d       = frame_last_c;
            last_empty_d = frame_empty_c;
            m_valid_d    = 1'b1;
            m_data_d     = frame_c[BEAT_W-1:0];
            m_sop_d      = 1'b1;
            m_eop_d      = 1'b0;
            m_empty_d    = 3'd0;
          end else begin
            drop_cnt_d = drop_cnt + 16'd1;
          end
        end
      end
      S_SEND: begin
        if (m_ready) begin
          if (m_eop) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_sop_d   = 1'b0;
            m_eop_d   = 1'b0;
            m_empty_d = 3'd0;
            msg_cnt_d = msg_cnt + 32'd1;
            gap_cnt_d = GAP_W'(IDLE_GAP - 1);
          end else begin
            beat_d    = beat_nx;
            m_data_d  = (beat_nx == 2'd2) ? frame_buf[2*BEAT_W +: BEAT_W]
                                          : frame_buf[BEAT_W +: BEAT_W];
            m_sop_d   = 1'b0;
            m_eop_d   = (beat_nx == last);
            m_empty_d = (beat_nx == last) ? last_empty : 3'd0;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt != '0) gap_cnt_d = gap_cnt - GAP_W'(1);
      end
      default: ;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  // Frame buffer and beat bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_buf  <= '0;
      beat       <= 2'd0;
      last       <= 2'd0;
      last_empty <= 3'd0;
      gap_cnt    <= '0;
    end else begin
      frame_buf  <= frame_buf_d;
      beat       <= beat_d;
      last       <= last_d;
      last_empty <= last_empty_d;
      gap_cnt    <= gap_cnt_d;
    end
  end

  // Registered stream outputs, handshake and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b1;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_sop    <= 1'b0;
      m_eop    <= 1'b0;
      m_empty  <= 3'd0;
      msg_cnt  <= 32'd0;
      drop_cnt <= 16'd0;
    end else begin
      in_ready <= in_ready_d;
      m_valid  <= m_valid_d;
      m_data   <= m_data_d;
      m_sop    <= m_sop_d;
      m_eop    <= m_eop_d;
      m_empty  <= m_empty_d;
      msg_cnt  <= msg_cnt_d;
      drop_cnt <= drop_cnt_d;
    end
  end

endmodule
